// File: rtl/bomb_countdown.sv
// Bomb countdown timer: SS.t BCD digits decremented per 100 ms tick while armed,
// with strike penalties, defuse and a one-cycle boom pulse on expiry.
module bomb_countdown #(
    parameter logic [3:0] INIT_TENS   = 4'd6,
    parameter logic [3:0] INIT_ONES   = 4'd0,
    parameter logic [3:0] PENALTY_S   = 4'd5,
    parameter logic [1:0] MAX_STRIKES = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_100ms,
    input  logic       arm,
    input  logic       pause,
    input  logic       defuse,
    input  logic       strike,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] tenths,
    output logic [1:0] strikes,
    output logic       running,
    output logic       defused,
    output logic       expired,
    output logic       boom
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SECS_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_DEFUSED = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    state_t state;

    logic [SECS_W-1:0]  secs;
    logic [SECS_W-1:0]  pen_secs;
    logic [DIGIT_W-1:0] pen_tens;
    logic [DIGIT_W-1:0] pen_ones;
    logic [1:0]         strikes_inc;
    logic               strike_kill;
    logic               tick_last;

    // Strike penalty arithmetic and terminal-count detection
    always_comb begin
        secs        = SECS_W'(sec_tens) * SECS_W'(10) + SECS_W'(sec_ones);
        pen_secs    = secs - SECS_W'(PENALTY_S);
        pen_tens    = DIGIT_W'(pen_secs / SECS_W'(10));
        pen_ones    = DIGIT_W'(pen_secs % SECS_W'(10));
        strikes_inc = (strikes == MAX_STRIKES) ? strikes : strikes + 2'd1;
        strike_kill = (secs < SECS_W'(PENALTY_S))
                   || ((pen_secs == '0) && (tenths == '0))
                   || (strikes_inc >= MAX_STRIKES);
        tick_last   = (sec_tens == '0) && (sec_ones == '0) && (tenths <= DIGIT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sec_tens <= INIT_TENS;
            sec_ones <= INIT_ONES;
            tenths   <= '0;
            strikes  <= '0;
            running  <= 1'b0;
            defused  <= 1'b0;
            expired  <= 1'b0;
            boom     <= 1'b0;
        end else begin
            boom <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm && !pause) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (defuse) begin
                        state   <= ST_DEFUSED;
                        running <= 1'b0;
                        defused <= 1'b1;
                    end else if (strike) begin
                        strikes <= strikes_inc;
                        if (strike_kill) begin
                            sec_tens <= '0;
                            sec_ones <= '0;
                            tenths   <= '0;
                            state    <= ST_EXPIRED;
                            running  <= 1'b0;
                            expired  <= 1'b1;
                            boom     <= 1'b1;
                        end else begin
                            sec_tens <= pen_tens;
                            sec_ones <= pen_ones;
                        end
                    end else if (tick_100ms && (state == ST_RUN)) begin
                        if (tick_last) begin
                            sec_tens <= '0;
                            sec_ones <= '0;
                            tenths   <= '0;
                            state    <= ST_EXPIRED;
                            running  <= 1'b0;
                            expired  <= 1'b1;
                            boom     <= 1'b1;
                        end else if (tenths != '0) begin
                            tenths <= tenths - DIGIT_W'(1);
                        end else begin
                            // BCD borrow chain; tick_last guarantees tens never underflows
                            tenths <= DIGIT_W'(9);
                            if (sec_ones != '0) begin
                                sec_ones <= sec_ones - DIGIT_W'(1);
                            end else begin
                                sec_ones <= DIGIT_W'(9);
                                sec_tens <= sec_tens - DIGIT_W'(1);
                            end
                        end
                    end else if (pause) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (arm && (state == ST_PAUSE)) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    // DEFUSED and EXPIRED are terminal until reset
                end
            endcase
        end
    end

endmodule
